// File: rtl/ddr_port_arbiter.sv
// Multi-port front end for the DDR controller user interface: independent read and
// write arbiters (round-robin or fixed priority), write-burst locking, tagged read return.
module ddr_port_arbiter #(
    parameter int PORTS       = 4,
    parameter int OWNERS      = 2,
    parameter int UADDR       = 23,
    parameter int UWIDTH      = 32,
    parameter int UBYTES      = 4,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,

    input  logic [PORTS-1:0]          p_rd_req_i,
    input  logic [PORTS-1:0]          p_rd_block_i,
    input  logic [PORTS*UADDR-1:0]    p_rd_addr_i,
    output logic [PORTS-1:0]          p_rd_ack_o,

    input  logic [PORTS-1:0]          p_wr_req_i,
    input  logic [PORTS-1:0]          p_wr_block_i,
    input  logic [PORTS*UADDR-1:0]    p_wr_addr_i,
    input  logic [PORTS*UBYTES-1:0]   p_wr_bes_ni,
    input  logic [PORTS*UWIDTH-1:0]   p_wr_data_i,
    output logic [PORTS-1:0]          p_wr_ack_o,

    output logic [PORTS-1:0]          p_rd_ready_o,
    output logic [UWIDTH-1:0]         p_rd_data_o,

    output logic                      rd_req_o,
    output logic                      rd_block_o,
    output logic [OWNERS-1:0]         rd_owner_o,
    output logic [UADDR-1:0]          rd_addr_o,
    input  logic                      rd_busy_i,

    output logic                      wr_req_o,
    output logic                      wr_block_o,
    output logic [UADDR-1:0]          wr_addr_o,
    output logic [UBYTES-1:0]         wr_bes_no,
    output logic [UWIDTH-1:0]         wr_data_o,
    input  logic                      wr_busy_i,

    input  logic [OWNERS-1:0]         rd_owner_i,
    input  logic [UWIDTH-1:0]         rd_data_i,
    input  logic                      rd_ready_i
);

    // Handshake: a port request is consumed on the rising edge where its p_*_ack_o bit
    // is 1; acks are combinational, only raised while the matching *_busy_i is 0, and the
    // accepted request appears on the controller side for exactly one cycle afterwards.

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_LOCK = 1'b1
    } wr_state_t;

    wr_state_t         wr_state;
    wr_state_t         wr_state_next;

    logic [OWNERS-1:0] rd_last;
    logic [OWNERS-1:0] wr_last;
    logic [OWNERS-1:0] lock_port;

    logic [PORTS-1:0]  rd_elig;
    logic [PORTS-1:0]  wr_elig;
    logic [PORTS-1:0]  lock_mask;
    logic [PORTS-1:0]  rd_onehot;
    logic [PORTS-1:0]  wr_onehot;

    logic              rd_found;
    logic              wr_found;
    logic [OWNERS-1:0] rd_sel;
    logic [OWNERS-1:0] wr_sel;
    logic              rd_sel_block;
    logic              wr_sel_block;

    // Returns {found, index}; the search starts after the last winner in round-robin mode.
    function automatic logic [OWNERS:0] arb_pick(input logic [PORTS-1:0] elig,
                                                  input logic [OWNERS-1:0] last);
        logic [OWNERS:0] res;
        int              base;
        int              idx;
        res  = '0;
        base = (ROUND_ROBIN != 0) ? (int'(last) + 1) % PORTS : 0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            idx = (base + i) % PORTS;
            if (|(elig & (PORTS'(1) << idx))) begin
                res = {1'b1, idx[OWNERS-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        rd_elig               = rd_busy_i ? '0 : p_rd_req_i;
        {rd_found, rd_sel}    = arb_pick(rd_elig, rd_last);
        rd_onehot             = PORTS'(1) << rd_sel;
        rd_sel_block          = |(p_rd_block_i & rd_onehot);
        p_rd_ack_o            = (rd_found && reset_ni) ? rd_onehot : '0;
    end

    // While locked only the burst owner may be acked, even if it is momentarily idle.
    always_comb begin
        lock_mask             = PORTS'(1) << lock_port;
        wr_elig               = '0;
        if (!wr_busy_i) begin
            wr_elig = (wr_state == WR_LOCK) ? (p_wr_req_i & lock_mask) : p_wr_req_i;
        end
        {wr_found, wr_sel}    = arb_pick(wr_elig, wr_last);
        wr_onehot             = PORTS'(1) << wr_sel;
        wr_sel_block          = |(p_wr_block_i & wr_onehot);
        p_wr_ack_o            = (wr_found && reset_ni) ? wr_onehot : '0;
    end

    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            WR_IDLE: if (wr_found && wr_sel_block)  wr_state_next = WR_LOCK;
            WR_LOCK: if (wr_found && !wr_sel_block) wr_state_next = WR_IDLE;
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_state  <= WR_IDLE;
            lock_port <= '0;
        end else begin
            wr_state <= wr_state_next;
            if (wr_found) begin
                lock_port <= wr_sel;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_req_o   <= 1'b0;
            rd_block_o <= 1'b0;
            rd_owner_o <= '0;
            rd_addr_o  <= '0;
            rd_last    <= OWNERS'(PORTS - 1);
        end else begin
            rd_req_o <= rd_found;
            if (rd_found) begin
                rd_block_o <= rd_sel_block;
                rd_owner_o <= rd_sel;
                rd_addr_o  <= p_rd_addr_i[int'(rd_sel)*UADDR +: UADDR];
                rd_last    <= rd_sel;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_req_o   <= 1'b0;
            wr_block_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_bes_no  <= '0;
            wr_data_o  <= '0;
            wr_last    <= OWNERS'(PORTS - 1);
        end else begin
            wr_req_o <= wr_found;
            if (wr_found) begin
                wr_block_o <= wr_sel_block;
                wr_addr_o  <= p_wr_addr_i[int'(wr_sel)*UADDR +: UADDR];
                wr_bes_no  <= p_wr_bes_ni[int'(wr_sel)*UBYTES +: UBYTES];
                wr_data_o  <= p_wr_data_i[int'(wr_sel)*UWIDTH +: UWIDTH];
                wr_last    <= wr_sel;
            end
        end
    end

    // Returns tagged with a non-existent owner still drive the data bus but raise no ready.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            p_rd_ready_o <= '0;
            p_rd_data_o  <= '0;
        end else begin
            p_rd_ready_o <= '0;
            if (rd_ready_i) begin
                p_rd_data_o <= rd_data_i;
                if (int'(rd_owner_i) < PORTS) begin
                    p_rd_ready_o <= PORTS'(1) << rd_owner_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: a 4-port round-robin instance and a 3-port fixed-priority
// instance share stimulus and are checked against a per-cycle behavioural model.
module tb_ddr_port_arbiter;

    localparam int UA = 23;
    localparam int UW = 32;
    localparam int UB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic [3:0]    rd_req, rd_block, wr_req, wr_block;
    logic [UA-1:0] rd_addr [4];
    logic [UA-1:0] wr_addr [4];
    logic [UB-1:0] wr_bes  [4];
    logic [UW-1:0] wr_data [4];
    logic          rd_busy, wr_busy, ret_ready;
    logic [1:0]    ret_owner;
    logic [UW-1:0] ret_data;

    logic [4*UA-1:0] rd_addr_bus, wr_addr_bus;
    logic [4*UB-1:0] wr_bes_bus;
    logic [4*UW-1:0] wr_data_bus;
    assign rd_addr_bus = {rd_addr[3], rd_addr[2], rd_addr[1], rd_addr[0]};
    assign wr_addr_bus = {wr_addr[3], wr_addr[2], wr_addr[1], wr_addr[0]};
    assign wr_bes_bus  = {wr_bes[3], wr_bes[2], wr_bes[1], wr_bes[0]};
    assign wr_data_bus = {wr_data[3], wr_data[2], wr_data[1], wr_data[0]};

    logic [3:0] a_rd_ack, a_wr_ack, a_rdy;
    logic [2:0] b_rd_ack, b_wr_ack, b_rdy;
    logic [3:0] o_rd_ack [2];
    logic [3:0] o_wr_ack [2];
    logic [3:0] o_rdy    [2];
    assign o_rd_ack[0] = a_rd_ack;
    assign o_rd_ack[1] = {1'b0, b_rd_ack};
    assign o_wr_ack[0] = a_wr_ack;
    assign o_wr_ack[1] = {1'b0, b_wr_ack};
    assign o_rdy[0]    = a_rdy;
    assign o_rdy[1]    = {1'b0, b_rdy};

    logic [UW-1:0] o_rdata    [2];
    logic          o_rd_req   [2];
    logic          o_rd_block [2];
    logic [1:0]    o_rd_owner [2];
    logic [UA-1:0] o_rd_addr  [2];
    logic          o_wr_req   [2];
    logic          o_wr_block [2];
    logic [UA-1:0] o_wr_addr  [2];
    logic [UB-1:0] o_wr_bes   [2];
    logic [UW-1:0] o_wr_data  [2];

    ddr_port_arbiter #(.PORTS(4), .OWNERS(2), .UADDR(UA), .UWIDTH(UW), .UBYTES(UB),
                       .ROUND_ROBIN(1)) dut_rr (
        .clock_i(clk), .reset_ni(rst_n),
        .p_rd_req_i(rd_req), .p_rd_block_i(rd_block), .p_rd_addr_i(rd_addr_bus),
        .p_rd_ack_o(a_rd_ack),
        .p_wr_req_i(wr_req), .p_wr_block_i(wr_block), .p_wr_addr_i(wr_addr_bus),
        .p_wr_bes_ni(wr_bes_bus), .p_wr_data_i(wr_data_bus), .p_wr_ack_o(a_wr_ack),
        .p_rd_ready_o(a_rdy), .p_rd_data_o(o_rdata[0]),
        .rd_req_o(o_rd_req[0]), .rd_block_o(o_rd_block[0]), .rd_owner_o(o_rd_owner[0]),
        .rd_addr_o(o_rd_addr[0]), .rd_busy_i(rd_busy),
        .wr_req_o(o_wr_req[0]), .wr_block_o(o_wr_block[0]), .wr_addr_o(o_wr_addr[0]),
        .wr_bes_no(o_wr_bes[0]), .wr_data_o(o_wr_data[0]), .wr_busy_i(wr_busy),
        .rd_owner_i(ret_owner), .rd_data_i(ret_data), .rd_ready_i(ret_ready)
    );

    ddr_port_arbiter #(.PORTS(3), .OWNERS(2), .UADDR(UA), .UWIDTH(UW), .UBYTES(UB),
                       .ROUND_ROBIN(0)) dut_fx (
        .clock_i(clk), .reset_ni(rst_n),
        .p_rd_req_i(rd_req[2:0]), .p_rd_block_i(rd_block[2:0]),
        .p_rd_addr_i(rd_addr_bus[3*UA-1:0]), .p_rd_ack_o(b_rd_ack),
        .p_wr_req_i(wr_req[2:0]), .p_wr_block_i(wr_block[2:0]),
        .p_wr_addr_i(wr_addr_bus[3*UA-1:0]), .p_wr_bes_ni(wr_bes_bus[3*UB-1:0]),
        .p_wr_data_i(wr_data_bus[3*UW-1:0]), .p_wr_ack_o(b_wr_ack),
        .p_rd_ready_o(b_rdy), .p_rd_data_o(o_rdata[1]),
        .rd_req_o(o_rd_req[1]), .rd_block_o(o_rd_block[1]), .rd_owner_o(o_rd_owner[1]),
        .rd_addr_o(o_rd_addr[1]), .rd_busy_i(rd_busy),
        .wr_req_o(o_wr_req[1]), .wr_block_o(o_wr_block[1]), .wr_addr_o(o_wr_addr[1]),
        .wr_bes_no(o_wr_bes[1]), .wr_data_o(o_wr_data[1]), .wr_busy_i(wr_busy),
        .rd_owner_i(ret_owner), .rd_data_i(ret_data), .rd_ready_i(ret_ready)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard counters and checker
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: d=0 is 4-port round-robin, d=1 is 3-port fixed priority
    int            m_rd_last [2];
    int            m_wr_last [2];
    int            m_lock_port [2];
    bit            m_lock [2];
    bit            e_rd_req [2], e_rd_block [2], e_wr_req [2], e_wr_block [2];
    int            e_rd_owner [2];
    logic [UA-1:0] e_rd_addr [2], e_wr_addr [2];
    logic [UB-1:0] e_wr_bes [2];
    logic [UW-1:0] e_wr_data [2], e_rdata [2];
    logic [3:0]    e_rdy [2];
    logic [3:0]    seen_rd_ack [2], seen_wr_ack [2];

    function automatic int nports(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int pick(input int d, input logic [3:0] req, input int last);
        int n;
        n = nports(d);
        for (int i = 0; i < n; i++) begin
            int p;
            p = (d == 0) ? (last + 1 + i) % n : i;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [3:0] bit_of(input int g);
        return (g >= 0) ? 4'(1 << g) : 4'h0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rd_last[d] = nports(d) - 1;
            m_wr_last[d] = nports(d) - 1;
            m_lock[d] = 1'b0;
            m_lock_port[d] = 0;
            e_rd_req[d] = 1'b0;
            e_wr_req[d] = 1'b0;
            e_rdy[d] = 4'h0;
            e_rdata[d] = '0;
        end
    endtask

    // One clock: check combinational acks, advance the model, check registered outputs.
    task automatic step();
        logic [3:0] m, re, we;
        int g;
        #1;
        for (int d = 0; d < 2; d++) begin
            m  = (d == 0) ? 4'hF : 4'h7;
            re = rd_busy ? 4'h0 : (rd_req & m);
            g  = pick(d, re, m_rd_last[d]);
            seen_rd_ack[d] = o_rd_ack[d];
            check($sformatf("rd_ack%0d", d), 64'(o_rd_ack[d]), 64'(bit_of(g)));
            e_rd_req[d] = (g >= 0);
            if (g >= 0) begin
                e_rd_addr[d]  = rd_addr[g];
                e_rd_block[d] = rd_block[g];
                e_rd_owner[d] = g;
                m_rd_last[d]  = g;
            end

            we = wr_busy ? 4'h0 : (wr_req & m);
            if (m_lock[d]) we = we & bit_of(m_lock_port[d]);
            g = pick(d, we, m_wr_last[d]);
            seen_wr_ack[d] = o_wr_ack[d];
            check($sformatf("wr_ack%0d", d), 64'(o_wr_ack[d]), 64'(bit_of(g)));
            e_wr_req[d] = (g >= 0);
            if (g >= 0) begin
                e_wr_addr[d]  = wr_addr[g];
                e_wr_block[d] = wr_block[g];
                e_wr_bes[d]   = wr_bes[g];
                e_wr_data[d]  = wr_data[g];
                m_wr_last[d]  = g;
                if (!m_lock[d] && wr_block[g]) begin
                    m_lock[d] = 1'b1;
                    m_lock_port[d] = g;
                end else if (m_lock[d] && !wr_block[g]) begin
                    m_lock[d] = 1'b0;
                end
            end

            e_rdy[d] = (ret_ready && int'(ret_owner) < nports(d)) ? bit_of(int'(ret_owner)) : 4'h0;
            if (ret_ready) e_rdata[d] = ret_data;
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rd_req%0d", d), 64'(o_rd_req[d]), 64'(e_rd_req[d]));
            if (e_rd_req[d]) begin
                check($sformatf("rd_addr%0d", d), 64'(o_rd_addr[d]), 64'(e_rd_addr[d]));
                check($sformatf("rd_owner%0d", d), 64'(o_rd_owner[d]), 64'(e_rd_owner[d]));
                check($sformatf("rd_block%0d", d), 64'(o_rd_block[d]), 64'(e_rd_block[d]));
            end
            check($sformatf("wr_req%0d", d), 64'(o_wr_req[d]), 64'(e_wr_req[d]));
            if (e_wr_req[d]) begin
                check($sformatf("wr_addr%0d", d), 64'(o_wr_addr[d]), 64'(e_wr_addr[d]));
                check($sformatf("wr_data%0d", d), 64'(o_wr_data[d]), 64'(e_wr_data[d]));
                check($sformatf("wr_bes%0d", d), 64'(o_wr_bes[d]), 64'(e_wr_bes[d]));
                check($sformatf("wr_block%0d", d), 64'(o_wr_block[d]), 64'(e_wr_block[d]));
            end
            check($sformatf("rd_ready%0d", d), 64'(o_rdy[d]), 64'(e_rdy[d]));
            check($sformatf("rd_data%0d", d), 64'(o_rdata[d]), 64'(e_rdata[d]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_rd_ack%0d", tag, d), 64'(o_rd_ack[d]), 64'h0);
            check($sformatf("%s_wr_ack%0d", tag, d), 64'(o_wr_ack[d]), 64'h0);
            check($sformatf("%s_rd_req%0d", tag, d), 64'(o_rd_req[d]), 64'h0);
            check($sformatf("%s_wr_req%0d", tag, d), 64'(o_wr_req[d]), 64'h0);
            check($sformatf("%s_rdy%0d", tag, d), 64'(o_rdy[d]), 64'h0);
            check($sformatf("%s_rdata%0d", tag, d), 64'(o_rdata[d]), 64'h0);
            check($sformatf("%s_wdata%0d", tag, d), 64'(o_wr_data[d]), 64'h0);
            check($sformatf("%s_raddr%0d", tag, d), 64'(o_rd_addr[d]), 64'h0);
        end
    endtask

    task automatic clear_inputs();
        rd_req = '0; rd_block = '0; wr_req = '0; wr_block = '0;
        rd_busy = 1'b0; wr_busy = 1'b0; ret_ready = 1'b0; ret_owner = '0; ret_data = '0;
        for (int i = 0; i < 4; i++) begin
            rd_addr[i] = UA'(32'h10 * (i + 1));
            wr_addr[i] = UA'(32'h1000 + i);
            wr_bes[i]  = UB'(i);
            wr_data[i] = 32'hA000_0000 + i;
        end
    endtask

    task automatic randomize_inputs();
        rd_req   = 4'($urandom);
        rd_block = 4'($urandom);
        wr_req   = 4'($urandom);
        wr_block = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            rd_addr[i] = UA'($urandom);
            wr_addr[i] = UA'($urandom);
            wr_bes[i]  = UB'($urandom);
            wr_data[i] = $urandom;
        end
        rd_busy   = ($urandom_range(0, 3) == 0);
        wr_busy   = ($urandom_range(0, 3) == 0);
        ret_ready = ($urandom_range(0, 1) == 1);
        ret_owner = 2'($urandom_range(0, 3));
        ret_data  = $urandom;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        rd_req = 4'hF;
        wr_req = 4'hF;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        // Round-robin read: port 0 then port 2
        rd_addr[0] = UA'(32'h100);
        rd_addr[2] = UA'(32'h200);
        rd_req = 4'b0101;
        step();
        check("rr_first_ack", 64'(seen_rd_ack[0]), 64'h1);
        check("rr_first_owner", 64'(o_rd_owner[0]), 64'h0);
        rd_req = rd_req & ~seen_rd_ack[0];
        step();
        check("rr_second_ack", 64'(seen_rd_ack[0]), 64'h4);
        check("rr_second_owner", 64'(o_rd_owner[0]), 64'h2);
        check("rr_second_addr", 64'(o_rd_addr[0]), 64'h200);
        rd_req = '0;

        // Fixed priority: port 1 always beats port 2
        rd_req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fixed_ack", 64'(seen_rd_ack[1]), 64'h2);
        end
        rd_req = '0;

        // Write burst lock: port 0 single word first so port 1 is next in round-robin
        wr_req = 4'b0001;
        wr_data[0] = 32'h0000_0F00;
        step();
        wr_req = 4'b0011;
        wr_data[1] = 32'h1111_0001; wr_block[1] = 1'b1;
        step();
        check("lock_w0_ack", 64'(seen_wr_ack[0]), 64'h2);
        check("lock_w0_data", 64'(o_wr_data[0]), 64'h1111_0001);
        wr_req[1] = 1'b0;
        step();
        check("lock_idle_ack", 64'(seen_wr_ack[0]), 64'h0);
        wr_req[1] = 1'b1; wr_data[1] = 32'h1111_0002;
        step();
        check("lock_w1_ack", 64'(seen_wr_ack[0]), 64'h2);
        check("lock_w1_data", 64'(o_wr_data[0]), 64'h1111_0002);
        wr_data[1] = 32'h1111_0003; wr_block[1] = 1'b0;
        step();
        check("lock_w2_ack", 64'(seen_wr_ack[0]), 64'h2);
        check("lock_w2_data", 64'(o_wr_data[0]), 64'h1111_0003);
        wr_req[1] = 1'b0;
        step();
        check("unlock_ack", 64'(seen_wr_ack[0]), 64'h1);
        check("unlock_data", 64'(o_wr_data[0]), 64'h0000_0F00);
        wr_req = '0;

        // Read busy holds off port 3
        rd_req = 4'b1000;
        rd_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("busy_ack", 64'(seen_rd_ack[0]), 64'h0);
            check("busy_req", 64'(o_rd_req[0]), 64'h0);
        end
        rd_busy = 1'b0;
        step();
        check("busy_release_ack", 64'(seen_rd_ack[0]), 64'h8);
        check("busy_release_owner", 64'(o_rd_owner[0]), 64'h3);
        rd_req = '0;

        // Return path, including an owner that the 3-port instance does not have
        ret_ready = 1'b1; ret_owner = 2'd2; ret_data = 32'hDEAD_BEEF;
        step();
        check("ret_rdy_o2", 64'(o_rdy[0]), 64'h4);
        check("ret_data_o2", 64'(o_rdata[0]), 64'hDEAD_BEEF);
        ret_owner = 2'd3; ret_data = 32'h1234_5678;
        step();
        check("ret_rdy_o3_4p", 64'(o_rdy[0]), 64'h8);
        check("ret_rdy_o3_3p", 64'(o_rdy[1]), 64'h0);
        check("ret_data_o3_3p", 64'(o_rdata[1]), 64'h1234_5678);
        ret_ready = 1'b0;

        // Reset in the middle of a locked burst
        wr_req = 4'b0100; wr_block[2] = 1'b1;
        step();
        rd_req = 4'hF; wr_req = 4'hF;
        #2 rst_n = 1'b0;
        #1 check_all_zero("midlock");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_rd", 64'(seen_rd_ack[0]), 64'h1);
        check("post_reset_wr", 64'(seen_wr_ack[0]), 64'h1);
        check("post_reset_wr_fx", 64'(seen_wr_ack[1]), 64'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
